// File: rtl/astro_pkg.sv
// Shared definitions for the node path sequencer: turn codes and FSM state encoding.
package astro_pkg;

  localparam logic [1:0] TURN_STRAIGHT = 2'd0;
  localparam logic [1:0] TURN_RIGHT    = 2'd1;
  localparam logic [1:0] TURN_UTURN    = 2'd2;
  localparam logic [1:0] TURN_LEFT     = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RUN     = 3'd1,
    ST_AT_NODE = 3'd2,
    ST_DONE    = 3'd3,
    ST_FAULT   = 3'd4
  } seq_state_t;

endpackage

// File: rtl/path_mem.sv
// Route memory: DEPTH x 2-bit turn codes, one synchronous write port,
// one combinational read port, cleared to STRAIGHT on reset.
module path_mem
  import astro_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk_3125KHz,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [1:0]    wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [1:0]    rd_data
);

  logic [1:0] entries [DEPTH];

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      logic [1:0] entry_reg;

      always_ff @(posedge clk_3125KHz or negedge rst_n) begin
        if (!rst_n) begin
          entry_reg <= TURN_STRAIGHT;
        end else if (wr_en && (wr_addr == AW'(gi))) begin
          entry_reg <= wr_data;
        end
      end

      assign entries[gi] = entry_reg;
    end
  endgenerate

  assign rd_data = entries[rd_addr];

endmodule

// File: rtl/node_path_sequencer.sv
// Walks the line follower through a stored route of turn codes, one entry per
// node, with a minimum dwell per node and a progress watchdog.
module node_path_sequencer
  import astro_pkg::*;
#(
  parameter int DEPTH        = 16,
  parameter int AW           = 4,
  parameter int TURN_MIN_CYC = 3125,
  parameter int TIMEOUT_CYC  = 31_250_000
) (
  input  logic          clk_3125KHz,
  input  logic          rst_n,
  input  logic          start,
  input  logic          abort,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [1:0]    wr_data,
  input  logic [AW:0]   path_len,
  input  logic          node_flag,
  input  logic          node_changed,
  output logic [1:0]    turn_flag,
  output logic          end_path,
  output logic          busy,
  output logic          fault,
  output logic [AW:0]   node_idx
);

  localparam int LW = AW + 1;
  localparam int HW = $clog2(TURN_MIN_CYC + 1);
  localparam int WW = $clog2(TIMEOUT_CYC);

  localparam logic [HW-1:0] HOLD_MAX  = HW'(TURN_MIN_CYC);
  localparam logic [HW-1:0] HOLD_EXIT = HW'(TURN_MIN_CYC - 1);
  localparam logic [WW-1:0] WD_LAST   = WW'(TIMEOUT_CYC - 1);
  localparam logic [LW-1:0] DEPTH_L   = LW'(DEPTH);

  seq_state_t    state_reg, state_next;
  logic [1:0]    turn_reg, turn_next;
  logic          end_path_reg, end_path_next;
  logic          busy_reg, busy_next;
  logic          fault_reg, fault_next;
  logic [LW-1:0] idx_reg, idx_next;
  logic [LW-1:0] len_reg, len_next;
  logic [HW-1:0] hold_reg, hold_next;
  logic [WW-1:0] wd_reg, wd_next;
  logic          pending_reg, pending_next;
  logic          node_flag_d_reg;

  logic          node_rise;
  logic [LW-1:0] idx_inc;
  logic [LW-1:0] start_len;
  logic [AW-1:0] rd_addr;
  logic [1:0]    rd_data;

  assign node_rise = node_flag & ~node_flag_d_reg;
  assign idx_inc   = idx_reg + 1'b1;
  assign start_len = (path_len > DEPTH_L) ? DEPTH_L : path_len;
  // While idle the next route starts at entry 0; while running we prefetch the next entry.
  assign rd_addr   = busy_reg ? idx_inc[AW-1:0] : '0;

  path_mem #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_path_mem (
    .clk_3125KHz (clk_3125KHz),
    .rst_n       (rst_n),
    .wr_en       (wr_en & ~busy_reg),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data)
  );

  always_ff @(posedge clk_3125KHz or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= ST_IDLE;
      turn_reg        <= TURN_STRAIGHT;
      end_path_reg    <= 1'b1;
      busy_reg        <= 1'b0;
      fault_reg       <= 1'b0;
      idx_reg         <= '0;
      len_reg         <= '0;
      hold_reg        <= '0;
      wd_reg          <= '0;
      pending_reg     <= 1'b0;
      node_flag_d_reg <= 1'b0;
    end else begin
      state_reg       <= state_next;
      turn_reg        <= turn_next;
      end_path_reg    <= end_path_next;
      busy_reg        <= busy_next;
      fault_reg       <= fault_next;
      idx_reg         <= idx_next;
      len_reg         <= len_next;
      hold_reg        <= hold_next;
      wd_reg          <= wd_next;
      pending_reg     <= pending_next;
      node_flag_d_reg <= node_flag;
    end
  end

  always_comb begin
    state_next    = state_reg;
    turn_next     = turn_reg;
    end_path_next = end_path_reg;
    busy_next     = busy_reg;
    fault_next    = fault_reg;
    idx_next      = idx_reg;
    len_next      = len_reg;
    hold_next     = hold_reg;
    wd_next       = wd_reg;
    pending_next  = pending_reg;

    if (abort) begin
      state_next    = ST_IDLE;
      turn_next     = TURN_STRAIGHT;
      end_path_next = 1'b1;
      busy_next     = 1'b0;
      fault_next    = 1'b0;
      idx_next      = '0;
      hold_next     = '0;
      wd_next       = '0;
      pending_next  = 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE, ST_DONE, ST_FAULT: begin
          if (start) begin
            len_next     = start_len;
            idx_next     = '0;
            fault_next   = 1'b0;
            hold_next    = '0;
            wd_next      = '0;
            pending_next = 1'b0;
            if (start_len == '0) begin
              state_next    = ST_DONE;
              turn_next     = TURN_STRAIGHT;
              end_path_next = 1'b1;
              busy_next     = 1'b0;
            end else begin
              state_next    = ST_RUN;
              turn_next     = rd_data;
              end_path_next = 1'b0;
              busy_next     = 1'b1;
            end
          end
        end

        ST_RUN: begin
          if (wd_reg == WD_LAST) begin
            state_next    = ST_FAULT;
            turn_next     = TURN_STRAIGHT;
            end_path_next = 1'b1;
            busy_next     = 1'b0;
            fault_next    = 1'b1;
            wd_next       = '0;
          end else if (node_rise) begin
            state_next   = ST_AT_NODE;
            hold_next    = '0;
            wd_next      = '0;
            pending_next = 1'b0;
          end else begin
            wd_next = wd_reg + 1'b1;
          end
        end

        ST_AT_NODE: begin
          // The watchdog wins over a node exit landing on the same cycle.
          if (wd_reg == WD_LAST) begin
            state_next    = ST_FAULT;
            turn_next     = TURN_STRAIGHT;
            end_path_next = 1'b1;
            busy_next     = 1'b0;
            fault_next    = 1'b1;
            wd_next       = '0;
            hold_next     = '0;
            pending_next  = 1'b0;
          end else if ((pending_reg | node_changed) && (hold_reg >= HOLD_EXIT)) begin
            pending_next = 1'b0;
            wd_next      = '0;
            hold_next    = '0;
            idx_next     = idx_inc;
            if (idx_inc == len_reg) begin
              state_next    = ST_DONE;
              turn_next     = TURN_STRAIGHT;
              end_path_next = 1'b1;
              busy_next     = 1'b0;
            end else begin
              state_next = ST_RUN;
              turn_next  = rd_data;
            end
          end else begin
            wd_next = wd_reg + 1'b1;
            if (hold_reg != HOLD_MAX) begin
              hold_next = hold_reg + 1'b1;
            end
            if (node_changed) begin
              pending_next = 1'b1;
            end
          end
        end

        default: begin
          state_next = ST_IDLE;
        end
      endcase
    end
  end

  assign turn_flag = turn_reg;
  assign end_path  = end_path_reg;
  assign busy      = busy_reg;
  assign fault     = fault_reg;
  assign node_idx  = idx_reg;

endmodule

// File: tb/tb_node_path_sequencer.sv
// Self-checking bench for node_path_sequencer: start-vector table, hand-written
// corner sequences and randomized routes against a route-level reference model.
module tb_node_path_sequencer;

  localparam int DEPTH = 16;
  localparam int AW    = 4;
  localparam int TMIN  = 20;
  localparam int TOUT  = 300;

  logic          clk_3125KHz;
  logic          rst_n;
  logic          start;
  logic          abort;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [1:0]    wr_data;
  logic [AW:0]   path_len;
  logic          node_flag;
  logic          node_changed;
  logic [1:0]    turn_flag;
  logic          end_path;
  logic          busy;
  logic          fault;
  logic [AW:0]   node_idx;

  node_path_sequencer #(
    .DEPTH        (DEPTH),
    .AW           (AW),
    .TURN_MIN_CYC (TMIN),
    .TIMEOUT_CYC  (TOUT)
  ) dut (
    .clk_3125KHz  (clk_3125KHz),
    .rst_n        (rst_n),
    .start        (start),
    .abort        (abort),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .path_len     (path_len),
    .node_flag    (node_flag),
    .node_changed (node_changed),
    .turn_flag    (turn_flag),
    .end_path     (end_path),
    .busy         (busy),
    .fault        (fault),
    .node_idx     (node_idx)
  );

  initial clk_3125KHz = 1'b0;
  always #5 clk_3125KHz = ~clk_3125KHz;

  int total = 0;
  int bad   = 0;
  logic [1:0] mdl_mem [DEPTH];
  int cur_len;

  typedef struct {
    int         plen;
    logic       exp_busy;
    logic       exp_end;
    logic [1:0] exp_turn;
  } vec_t;
  vec_t vecs [6];

  task automatic tick();
    @(posedge clk_3125KHz);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic mem_write(input int a, input logic [1:0] d);
    wr_en   = 1'b1;
    wr_addr = a[AW-1:0];
    wr_data = d;
    tick();
    wr_en   = 1'b0;
    mdl_mem[a] = d;
  endtask

  // Write attempted while the route is running: the model memory must not change.
  task automatic busy_write();
    int a;
    a = $urandom_range(0, DEPTH - 1);
    wr_en   = 1'b1;
    wr_addr = a[AW-1:0];
    wr_data = ~mdl_mem[a];
    tick();
    wr_en   = 1'b0;
  endtask

  task automatic start_route(input int plen);
    path_len = plen[AW:0];
    start    = 1'b1;
    tick();
    start    = 1'b0;
    cur_len  = (plen > DEPTH) ? DEPTH : plen;
  endtask

  task automatic do_abort();
    abort = 1'b1;
    tick();
    abort = 1'b0;
  endtask

  // One node visit: dwell h cycles on the node, then exit pulse. Exit is
  // accepted once the dwell has covered TMIN-1 counted cycles.
  task automatic visit(input int k, input int h, input int gap);
    int extra;
    repeat (gap) tick();
    check("pre_turn", turn_flag, mdl_mem[k]);
    check("pre_idx", node_idx, k);
    check("pre_busy", busy, 1);
    node_flag = 1'b1;
    tick();
    repeat (h) tick();
    node_flag    = 1'b0;
    node_changed = 1'b1;
    tick();
    node_changed = 1'b0;
    extra = (h >= TMIN - 1) ? 0 : (TMIN - 1 - h);
    for (int i = 0; i < extra; i++) begin
      check("held_idx", node_idx, k);
      tick();
    end
    check("post_idx", node_idx, k + 1);
    if (k + 1 == cur_len) begin
      check("done_end", end_path, 1);
      check("done_busy", busy, 0);
      check("done_turn", turn_flag, 0);
    end else begin
      check("next_turn", turn_flag, mdl_mem[k + 1]);
      check("next_busy", busy, 1);
      check("next_end", end_path, 0);
    end
  endtask

  initial begin
    #800_000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1, "bench time limit");
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; wr_en = 1'b0;
    wr_addr = '0; wr_data = '0; path_len = '0;
    node_flag = 1'b0; node_changed = 1'b0;
    cur_len = 0;
    for (int i = 0; i < DEPTH; i++) mdl_mem[i] = 2'd0;

    vecs[0] = '{plen: 0,  exp_busy: 1'b0, exp_end: 1'b1, exp_turn: 2'd0};
    vecs[1] = '{plen: 1,  exp_busy: 1'b1, exp_end: 1'b0, exp_turn: 2'd2};
    vecs[2] = '{plen: 3,  exp_busy: 1'b1, exp_end: 1'b0, exp_turn: 2'd2};
    vecs[3] = '{plen: 16, exp_busy: 1'b1, exp_end: 1'b0, exp_turn: 2'd2};
    vecs[4] = '{plen: 20, exp_busy: 1'b1, exp_end: 1'b0, exp_turn: 2'd2};
    vecs[5] = '{plen: 31, exp_busy: 1'b1, exp_end: 1'b0, exp_turn: 2'd2};

    // Reset state
    repeat (2) tick();
    check("rst_end", end_path, 1);
    check("rst_busy", busy, 0);
    check("rst_fault", fault, 0);
    check("rst_idx", node_idx, 0);
    check("rst_turn", turn_flag, 0);
    rst_n = 1'b1;
    tick();
    $display("reset: checked");

    // Start-vector table
    mem_write(0, 2'd2);
    for (int v = 0; v < 6; v++) begin
      start_route(vecs[v].plen);
      check("vec_busy", busy, vecs[v].exp_busy);
      check("vec_end", end_path, vecs[v].exp_end);
      check("vec_turn", turn_flag, vecs[v].exp_turn);
      check("vec_idx", node_idx, 0);
      if (vecs[v].exp_busy) begin
        path_len = '0;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("vec_restart_ignored", busy, 1);
      end
      do_abort();
      check("vec_abort_busy", busy, 0);
      check("vec_abort_end", end_path, 1);
      $display("vector %0d: path_len=%0d", v, vecs[v].plen);
    end

    // Three-node route
    mem_write(0, 2'd1); mem_write(1, 2'd3); mem_write(2, 2'd0);
    start_route(3);
    for (int k = 0; k < 3; k++) visit(k, 50, 2);
    check("route3_idx", node_idx, 3);
    $display("route [1,3,0]: finished");

    // Early exit pulse is held until minimum dwell, then advances exactly once
    start_route(2);
    visit(0, 5, 3);
    repeat (3) tick();
    check("defer_idx_once", node_idx, 1);
    do_abort();
    $display("deferred exit: checked");

    // Watchdog fault and recovery through start
    mem_write(0, 2'd3);
    start_route(4);
    repeat (TOUT - 1) tick();
    check("wd_before_fault", fault, 0);
    check("wd_before_busy", busy, 1);
    tick();
    check("wd_fault", fault, 1);
    check("wd_end", end_path, 1);
    check("wd_turn", turn_flag, 0);
    check("wd_busy", busy, 0);
    start_route(4);
    check("wd_restart_fault", fault, 0);
    check("wd_restart_idx", node_idx, 0);
    check("wd_restart_turn", turn_flag, 3);
    do_abort();
    $display("watchdog: checked");

    // Write on the start cycle hits the address being read: old value seen
    wr_en = 1'b1; wr_addr = '0; wr_data = 2'd1;
    start_route(1);
    wr_en = 1'b0;
    check("startwr_old", turn_flag, 3);
    mdl_mem[0] = 2'd1;
    do_abort();
    start_route(1);
    check("startwr_new", turn_flag, 1);
    do_abort();
    $display("start-cycle write: checked");

    // path_len above DEPTH clamps to a full 16-node route
    for (int i = 0; i < DEPTH; i++) mem_write(i, 2'($urandom_range(0, 3)));
    start_route(20);
    for (int k = 0; k < DEPTH; k++) visit(k, $urandom_range(0, 30), 1);
    check("clamp_idx", node_idx, 16);
    $display("clamp route: finished");

    // abort and start together while sitting on a node
    start_route(3);
    node_flag = 1'b1;
    tick();
    repeat (3) tick();
    abort = 1'b1; start = 1'b1;
    tick();
    abort = 1'b0; start = 1'b0; node_flag = 1'b0;
    check("abst_busy", busy, 0);
    check("abst_end", end_path, 1);
    check("abst_fault", fault, 0);
    check("abst_turn", turn_flag, 0);
    tick();
    check("abst_stays_idle", busy, 0);
    $display("abort+start: checked");

    // Randomized routes, with dropped writes while running
    for (int r = 0; r < 5; r++) begin
      int plen;
      plen = $urandom_range(1, 20);
      for (int w = 0; w < 4; w++) mem_write($urandom_range(0, DEPTH - 1), 2'($urandom_range(0, 3)));
      start_route(plen);
      for (int k = 0; k < cur_len; k++) begin
        if (k != 0 && ($urandom_range(0, 2) == 0)) busy_write();
        visit(k, $urandom_range(0, 60), $urandom_range(1, 10));
      end
      check("rand_idx", node_idx, cur_len);
      $display("random route %0d: path_len=%0d nodes=%0d", r, plen, cur_len);
    end

    // Reset in the middle of a route clears outputs and memory
    mem_write(0, 2'd3); mem_write(1, 2'd2);
    start_route(4);
    visit(0, 25, 1);
    rst_n = 1'b0;
    #1;
    check("mrst_end", end_path, 1);
    check("mrst_busy", busy, 0);
    check("mrst_fault", fault, 0);
    check("mrst_idx", node_idx, 0);
    check("mrst_turn", turn_flag, 0);
    for (int i = 0; i < DEPTH; i++) mdl_mem[i] = 2'd0;
    tick();
    rst_n = 1'b1;
    tick();
    start_route(2);
    check("mrst_mem_cleared", turn_flag, mdl_mem[0]);
    check("mrst_restart_busy", busy, 1);
    do_abort();
    $display("mid-route reset: checked");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
